flappy_led_game: RTL and testbench



---
 rtl/flappy_pkg.sv | 32 +++
 rtl/flappy_led_game_button_conditioner.sv | 64 ++++++
 rtl/flappy_led_game.sv | 174 +++++++++++++++++
 tb/tb_flappy_led_game.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/flappy_pkg.sv
// rtl/flappy_pkg.sv - shared types, constants and helpers for flappy_led_game
package flappy_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      OVER = 2'd2
   } state_e;

   localparam int LED_COUNT   = 6;
   localparam int ALT_MAX     = 5;
   localparam int START_ALT   = 3;
   localparam int FLAP_STEP   = 2;
   localparam logic [7:0] LFSR_SEED = 8'hA5;

   localparam int BTN_RESTART = 0;
   localparam int BTN_FLAP    = 2;

   // Fibonacci taps 8,6,5,4 map to bits 7,5,4,3.
   function automatic logic [7:0] lfsr_next(input logic [7:0] v);
      return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
   endfunction

   function automatic logic [2:0] gap_of(input logic [7:0] v);
      return 3'(v % 8'd5);
   endfunction

   function automatic logic [LED_COUNT-1:0] onehot(input logic [2:0] idx);
      return {{(LED_COUNT-1){1'b0}}, 1'b1} << idx;
   endfunction

endpackage

// File: rtl/flappy_led_game_button_conditioner.sv
// rtl/flappy_led_game_button_conditioner.sv - button synchronizer, optional debounce (FLAPPY_DEBOUNCE_EN), press detect
module button_conditioner #(
   parameter int WIDTH           = 1,
   parameter int DEBOUNCE_CYCLES = 270000
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [WIDTH-1:0] btn_n_i,
   output logic [WIDTH-1:0] press_o
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;
   logic [WIDTH-1:0] prev_q;
   logic [WIDTH-1:0] level;

   // Chain resets to the pressed level so a button held through reset never yields a falling edge.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= btn_n_i;
         sync_q <= meta_q;
      end
   end

`ifdef FLAPPY_DEBOUNCE_EN
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic [WIDTH-1:0] deb_q;
   logic [CW-1:0]    cnt_q [WIDTH];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         deb_q <= '0;
         for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (sync_q[i] == deb_q[i]) begin
               cnt_q[i] <= '0;
            end else if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
               deb_q[i] <= sync_q[i];
               cnt_q[i] <= '0;
            end else begin
               cnt_q[i] <= cnt_q[i] + 1'b1;
            end
         end
      end
   end

   assign level = deb_q;
`else
   assign level = sync_q;
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) prev_q <= '0;
      else         prev_q <= level;
   end

   assign press_o = prev_q & ~level;

endmodule

// File: rtl/flappy_led_game.sv
// rtl/flappy_led_game.sv - Flappy-Bird on a 6-LED bar; FLAPPY_DEBOUNCE_EN enables button debounce
module flappy_led_game
   import flappy_pkg::*;
#(
   parameter int TICK_DIV        = 3375000,
   parameter int PIPE_SPACING    = 6,
   parameter int DEBOUNCE_CYCLES = 270000
) (
   input  logic       clk_27M,
   input  logic       rst_n,
   input  logic [4:0] buttons_n,
   input  logic [3:0] switches,
   output logic [5:0] leds_n
);

   localparam int DW = $clog2(PIPE_SPACING);
   localparam logic [DW-1:0] DIST_RELOAD = DW'(PIPE_SPACING - 1);

   logic [4:0] press;
   logic       restart_p, flap_p;
   logic       unused_press;

   logic [3:0] sw_meta_q, sw_sync_q;
   logic [7:0] lfsr_q;

   logic [31:0] tick_cnt_q, tick_cnt_d, tick_lim_q, tick_lim_d, lim_sel;
   logic        tick;

   state_e          state_q, state_d;
   logic [2:0]      alt_q, alt_d, gap_q, gap_d;
   logic [DW-1:0]   dist_q, dist_d;
   logic [7:0]      score_q, score_d;
   logic            flap_pend_q, flap_pend_d;
   logic            crash;

   logic [LED_COUNT-1:0] lit, leds_d, leds_q;

   button_conditioner #(
      .WIDTH          (5),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_btn (
      .clk_i  (clk_27M),
      .rst_ni (rst_n),
      .btn_n_i(buttons_n),
      .press_o(press)
   );

   assign restart_p    = press[BTN_RESTART];
   assign flap_p       = press[BTN_FLAP];
   assign unused_press = ^{press[4], press[3], press[1]};

   always_ff @(posedge clk_27M or negedge rst_n) begin
      if (!rst_n) begin
         sw_meta_q <= '0;
         sw_sync_q <= '0;
         lfsr_q    <= LFSR_SEED;
      end else begin
         sw_meta_q <= switches;
         sw_sync_q <= sw_meta_q;
         lfsr_q    <= lfsr_next(lfsr_q);
      end
   end

   // Period is latched at each reload so a switch change only applies to the next tick interval.
   assign lim_sel = 32'(TICK_DIV) * (32'd16 - 32'(sw_sync_q));
   assign tick    = (state_q == PLAY) && (tick_cnt_q == tick_lim_q - 32'd1);

   always_comb begin
      tick_cnt_d = tick_cnt_q + 32'd1;
      tick_lim_d = tick_lim_q;
      if (state_q != PLAY || tick) begin
         tick_cnt_d = '0;
         tick_lim_d = lim_sel;
      end
   end

   always_ff @(posedge clk_27M or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         tick_cnt_q  <= '0;
         tick_lim_q  <= '0;
         alt_q       <= '0;
         gap_q       <= '0;
         dist_q      <= '0;
         score_q     <= '0;
         flap_pend_q <= 1'b0;
         leds_q      <= '1;
      end else begin
         state_q     <= state_d;
         tick_cnt_q  <= tick_cnt_d;
         tick_lim_q  <= tick_lim_d;
         alt_q       <= alt_d;
         gap_q       <= gap_d;
         dist_q      <= dist_d;
         score_q     <= score_d;
         flap_pend_q <= flap_pend_d;
         leds_q      <= leds_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      alt_d       = alt_q;
      gap_d       = gap_q;
      dist_d      = dist_q;
      score_d     = score_q;
      flap_pend_d = flap_pend_q;
      crash       = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!restart_p && flap_p) begin
               state_d     = PLAY;
               alt_d       = 3'(START_ALT);
               dist_d      = DIST_RELOAD;
               gap_d       = gap_of(lfsr_q);
               score_d     = '0;
               flap_pend_d = 1'b0;
            end
         end
         PLAY: begin
            if (restart_p) begin
               state_d = IDLE;
            end else begin
               flap_pend_d = flap_pend_q | flap_p;
               if (tick) begin
                  if (flap_pend_d) begin
                     alt_d       = (alt_q >= 3'(ALT_MAX - FLAP_STEP)) ? 3'(ALT_MAX)
                                                                       : alt_q + 3'(FLAP_STEP);
                     flap_pend_d = 1'b0;
                  end else if (alt_q == '0) begin
                     crash = 1'b1;
                  end else begin
                     alt_d = alt_q - 3'd1;
                  end
                  // The pipe check sees the altitude after this tick's move.
                  if (dist_q == '0) begin
                     if (alt_d != gap_q && alt_d != gap_q + 3'd1) begin
                        crash = 1'b1;
                     end else begin
                        score_d = score_q + 8'd1;
                        dist_d  = DIST_RELOAD;
                        gap_d   = gap_of(lfsr_q);
                     end
                  end else begin
                     dist_d = dist_q - 1'b1;
                  end
                  if (crash) state_d = OVER;
               end
            end
         end
         OVER: begin
            if (restart_p) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      lit = '0;
      unique case (state_q)
         IDLE: lit = {2'b00, sw_sync_q};
         PLAY: begin
            lit = onehot(alt_q);
            if (dist_q <= DW'(1)) lit = lit | ~(onehot(gap_q) | onehot(gap_q + 3'd1));
         end
         OVER:    lit = score_q[5:0];
         default: lit = '0;
      endcase
      leds_d = ~lit;
   end

   assign leds_n = leds_q;

endmodule

// File: tb/tb_flappy_led_game.sv
// tb/tb_flappy_led_game.sv - directed self-checking bench for flappy_led_game (TICK_DIV=2, PIPE_SPACING=4)
module tb_flappy_led_game;

   logic       clk_27M   = 1'b0;
   logic       rst_n     = 1'b0;
   logic [4:0] buttons_n = 5'h1F;
   logic [3:0] switches  = 4'd7;
   logic [5:0] leds_n;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int e_cyc    = 0;

   logic [7:0] m_lfsr;

   flappy_led_game #(
      .TICK_DIV       (2),
      .PIPE_SPACING   (4),
      .DEBOUNCE_CYCLES(8)
   ) dut (
      .clk_27M  (clk_27M),
      .rst_n    (rst_n),
      .buttons_n(buttons_n),
      .switches (switches),
      .leds_n   (leds_n)
   );

   always #5 clk_27M = ~clk_27M;

   function automatic logic [7:0] ref_step(input logic [7:0] v);
      return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
   endfunction

   always @(posedge clk_27M or negedge rst_n) begin
      if (!rst_n) m_lfsr <= 8'hA5;
      else        m_lfsr <= ref_step(m_lfsr);
   end

   task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk_27M);
         #1;
         cyc++;
      end
   endtask

   task automatic goto(input int rel);
      while (cyc - e_cyc < rel) step(1);
   endtask

   // The gap is captured from the LFSR value two edges after the flap is driven.
   task automatic start_game(input int gap);
      int tries = 0;
      while ((ref_step(ref_step(m_lfsr)) % 8'd5) != 8'(gap) && tries < 600) begin
         step(1);
         tries++;
      end
      if (tries >= 600) expect_eq("gap_search", 32'(tries), 32'd0);
      buttons_n[2] = 1'b0;
      step(3);
      e_cyc        = cyc;
      buttons_n[2] = 1'b1;
   endtask

   task automatic press(input logic [4:0] mask);
      buttons_n = buttons_n & ~mask;
      step(4);
      buttons_n = 5'h1F;
      step(3);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      step(2);
      expect_eq("reset_leds", 32'(leds_n), 32'h3F);
      rst_n = 1'b1;
      step(3);
      expect_eq("idle_leds", 32'(leds_n), 32'b111000);

      rst_n     = 1'b0;
      buttons_n = 5'b11011;
      step(2);
      rst_n = 1'b1;
      step(30);
      expect_eq("held_flap_idle", 32'(leds_n), 32'b111000);
      buttons_n = 5'h1F;
      step(5);
      expect_eq("held_release_idle", 32'(leds_n), 32'b111000);

`ifdef FLAPPY_DEBOUNCE_EN
      buttons_n[2] = 1'b0;
      step(5);
      buttons_n[2] = 1'b1;
      step(20);
      expect_eq("deb_short_ignored", 32'(leds_n), 32'b111000);
      buttons_n[2] = 1'b0;
      step(10);
      buttons_n[2] = 1'b1;
      step(5);
      expect_eq("deb_long_accepted", 32'(leds_n), 32'b110111);
`else
      // Free fall to the floor: alt 3,2,1,0 then crash.
      start_game(2);
      step(1);
      expect_eq("t1_entry", 32'(leds_n), 32'b110111);
      goto(19);
      expect_eq("t1_alt2", 32'(leds_n), 32'b111011);
      goto(37);
      expect_eq("t1_alt1_pipe", 32'(leds_n), 32'b001100);
      goto(55);
      expect_eq("t1_alt0_pipe", 32'(leds_n), 32'b001100);
      goto(73);
      expect_eq("t1_over_score0", 32'(leds_n), 32'h3F);
      press(5'b00001);
      expect_eq("t1_restart_idle", 32'(leds_n), 32'b111000);

      // Two presses before one tick lift by 2 only, then clear the pipe and crash later.
      start_game(2);
      step(1);
      expect_eq("t2_entry", 32'(leds_n), 32'b110111);
      goto(19);
      expect_eq("t2_alt2", 32'(leds_n), 32'b111011);
      goto(37);
      expect_eq("t2_alt1_pipe", 32'(leds_n), 32'b001100);
      press(5'b00100);
      press(5'b00100);
      goto(55);
      expect_eq("t2_double_flap", 32'(leds_n), 32'b000100);
      goto(73);
      expect_eq("t2_pipe_passed", 32'(leds_n), 32'b111011);
      goto(127);
      expect_eq("t2_over_score1", 32'(leds_n), 32'b111110);
      press(5'b00001);
      expect_eq("t2_restart_idle", 32'(leds_n), 32'b111000);

      // Gap at 4-5 keeps the top LEDs visible to show saturation.
      start_game(4);
      step(1);
      expect_eq("t3_entry", 32'(leds_n), 32'b110111);
      press(5'b00100);
      goto(19);
      expect_eq("t3_alt5", 32'(leds_n), 32'b011111);
      goto(37);
      expect_eq("t3_alt4_pipe", 32'(leds_n), 32'b100000);
      press(5'b00100);
      goto(55);
      expect_eq("t3_saturate", 32'(leds_n), 32'b010000);
      goto(73);
      expect_eq("t3_pass_high", 32'(leds_n), 32'b101111);
      press(5'b00101);
      expect_eq("t3_restart_flap_play", 32'(leds_n), 32'b111000);
      press(5'b00101);
      expect_eq("restart_flap_idle", 32'(leds_n), 32'b111000);

      start_game(2);
      step(5);
      rst_n = 1'b0;
      #1;
      expect_eq("midgame_reset", 32'(leds_n), 32'h3F);
      step(2);
      rst_n = 1'b1;
      step(3);
      expect_eq("after_reset_idle", 32'(leds_n), 32'b111000);

      switches = 4'hA;
      step(3);
      expect_eq("idle_switches", 32'(leds_n), 32'b110101);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
